mem_io_ctrl: RTL and testbench
==============================

# mem_io_ctrl

Memory and I/O access controller between the LC-3 datapath (MAR/MDR side) and the board's asynchronous 16-bit SRAM. It accepts one read or write request at a time over a req/ack handshake and sequences the active-low SRAM strobes with a programmable wait count. It also decodes one memory-mapped I/O address: reads return the switches and writes update the hex-display register.

## Interface
Parameters:
- WAIT_CYCLES, 2, extra SRAM access cycles beyond the first; legal range 0–15.
- IO_ADDR, 16'hFFFF, memory-mapped I/O address.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  access address (MAR value); sampled with req.
- wdata  in  16  write data (MDR value); sampled with req.
- S  in  16  switch inputs, read at IO_ADDR.
- rdata  out  16  read data; holds its value until the next completed read.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- hex_out  out  16  display register, written at IO_ADDR.
- SRAM_ADDR  out  20  {4'b0, latched addr}.
- SRAM_DQ  inout  16  SRAM data bus; driven only in WRITE and WR_HOLD, otherwise high-Z.
- CE, UB, LB, OE, WE  out  1  active-low SRAM strobes.

## Operation
- Request fields are latched into internal registers on acceptance; input changes after acceptance have no effect.
- States: IDLE, READ, WRITE, WR_HOLD, IO_ACC, ACK.
- IDLE, with req=1:
  - addr==IO_ADDR → IO_ACC.
  - else we=1 → WRITE.
  - else → READ.
  - On any of these transitions, the counter loads WAIT_CYCLES.
- READ:
  - Strobes: CE=0, OE=0, UB=LB=0, WE=1.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: rdata ← SRAM_DQ, then → ACK.
- WRITE:
  - Strobes: CE=0, WE=0, UB=LB=0, OE=1; SRAM_DQ driven with the latched wdata.
  - Counter decrements each cycle; when it is 0 → WR_HOLD.
- WR_HOLD: WE=1, CE=0, SRAM_DQ still driven (data hold time), then → ACK.
- IO_ACC: SRAM strobes all high. If we: hex_out ← wdata; else rdata ← S. Then → ACK.
- ACK: ack=1 for exactly one cycle, then → IDLE.
- req is ignored in every state other than IDLE.
- A req held high continuously produces back-to-back accesses: a new access is accepted in the IDLE cycle following ACK.
- In IDLE, ACK and IO_ACC, all strobes are 1 and SRAM_DQ is Z.

## Timing
- Cycle 0 is the edge at which req is sampled in IDLE.
- Read: READ occupies cycles 1..WAIT_CYCLES+1; ack is high in cycle WAIT_CYCLES+2; rdata is valid from that same cycle.
- Write: WRITE occupies cycles 1..WAIT_CYCLES+1; WR_HOLD is cycle WAIT_CYCLES+2; ack is high in cycle WAIT_CYCLES+3.
- I/O access: IO_ACC in cycle 1, ack in cycle 2.
- WAIT_CYCLES=0: READ and WRITE each last exactly one cycle.
- Reset (any state, including mid-access): at the next edge
  - state returns to IDLE;
  - rdata=0, hex_out=0, ack=0, busy=0;
  - all strobes=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - A write interrupted by reset is not guaranteed to complete in SRAM.
- Reset and req asserted together: reset wins and the request is discarded.
- Strobes, SRAM_ADDR and the SRAM_DQ output enable are registered outputs (no combinational decode glitches).

## Structure
- Shared package lc3_mem_pkg holds:
  - the state enum type mem_state_t;
  - the constant IO_ADDR_DEFAULT = 16'hFFFF;
  - the width constants SRAM_AW = 20 and DW = 16.
- Single module with no sub-module. The FSM, wait counter, request latch and tristate driver are small enough to stay in one file.

## Test plan
- Read, WAIT_CYCLES=2: the SRAM model returns 16'h1234 at 16'h0040; pulse req with we=0, addr=16'h0040 → OE=0 and CE=0 in cycles 1–3, ack in cycle 4, rdata=16'h1234.
- Write: we=1, addr=16'h0041, wdata=16'hBEEF → WE=0 in cycles 1–3, WE=1 with DQ still driving 16'hBEEF in cycle 4, ack in cycle 5; a subsequent read of 16'h0041 returns 16'hBEEF.
- I/O: with S=16'h00A5, read at 16'hFFFF → ack in cycle 2, rdata=16'h00A5, no SRAM strobe ever goes low; write 16'h0C3F at 16'hFFFF → hex_out=16'h0C3F.
- Reset mid-write: assert Reset in cycle 2 of a write → at the next edge state is IDLE, WE=1, DQ=Z, ack never pulses, hex_out=0.
- Back-to-back: hold req=1 across two reads with WAIT_CYCLES=0 → ack in cycle 2, the second access is accepted in cycle 3, ack again in cycle 5; req toggled during busy has no effect.
- Parameter sweep: WAIT_CYCLES=0 and 15 → read ack at cycle 2 and cycle 17 respectively.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory / I/O access controller.
// ctl_for() gives the SRAM strobe pattern that belongs to each controller state.
package lc3_mem_pkg;

    localparam int SRAM_AW = 20;
    localparam int DW      = 16;

    localparam logic [DW-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        WR_HOLD,
        IO_ACC,
        ACK
    } mem_state_t;

    // Active-low SRAM strobes plus the data-bus output enable (active high).
    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
        logic dq_oe;
    } sram_ctl_t;

    function automatic sram_ctl_t ctl_for(mem_state_t s);
        sram_ctl_t c;
        c = '{ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1, dq_oe: 1'b0};
        case (s)
            READ:    c = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b0, we: 1'b1, dq_oe: 1'b0};
            WRITE:   c = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b1, we: 1'b0, dq_oe: 1'b1};
            WR_HOLD: c = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b1, we: 1'b1, dq_oe: 1'b1};
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_io_ctrl.sv
// LC-3 memory and I/O access controller: req/ack front end, asynchronous SRAM
// sequencing with a programmable wait count, and one memory-mapped I/O address.
//
// state   | meaning
// IDLE    | waiting for req; latches the request on acceptance
// READ    | SRAM read strobes active, counting down the wait
// WRITE   | SRAM write strobes active, data driven, counting down the wait
// WR_HOLD | WE released while data stays driven for hold time
// IO_ACC  | switch read or hex-display write, SRAM untouched
// ACK     | one-cycle completion pulse
module mem_io_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned     WAIT_CYCLES = 2,
    parameter logic [DW-1:0]   IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req,
    input  logic                we,
    input  logic [DW-1:0]       addr,
    input  logic [DW-1:0]       wdata,
    input  logic [DW-1:0]       S,
    output logic [DW-1:0]       rdata,
    output logic                ack,
    output logic                busy,
    output logic [DW-1:0]       hex_out,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [DW-1:0]       SRAM_DQ,
    output logic                CE,
    output logic                UB,
    output logic                LB,
    output logic                OE,
    output logic                WE
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    mem_state_t     state_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [DW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  rdata_q;
    logic [DW-1:0]  hex_q;
    logic           ack_q;
    sram_ctl_t      ctl_q;

    // Strobes are loaded together with the state they belong to, so every
    // SRAM-facing output comes straight from a flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
            ack_q   <= 1'b0;
            ctl_q   <= ctl_for(IDLE);
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= WAIT_LD;
                        if (addr == IO_ADDR) begin
                            state_q <= IO_ACC;
                            ctl_q   <= ctl_for(IO_ACC);
                        end else if (we) begin
                            state_q <= WRITE;
                            ctl_q   <= ctl_for(WRITE);
                        end else begin
                            state_q <= READ;
                            ctl_q   <= ctl_for(READ);
                        end
                    end
                end
                READ: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q <= SRAM_DQ;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                        ctl_q   <= ctl_for(ACK);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WRITE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WR_HOLD;
                        ctl_q   <= ctl_for(WR_HOLD);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_HOLD: begin
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                    ctl_q   <= ctl_for(ACK);
                end
                IO_ACC: begin
                    if (we_q) begin
                        hex_q <= wdata_q;
                    end else begin
                        rdata_q <= S;
                    end
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                    ctl_q   <= ctl_for(ACK);
                end
                ACK: begin
                    state_q <= IDLE;
                    ctl_q   <= ctl_for(IDLE);
                end
                default: begin
                    state_q <= IDLE;
                    ctl_q   <= ctl_for(IDLE);
                end
            endcase
        end
    end

    assign SRAM_DQ   = ctl_q.dq_oe ? wdata_q : {DW{1'bz}};
    assign SRAM_ADDR = {{(SRAM_AW - DW){1'b0}}, addr_q};
    assign CE        = ctl_q.ce;
    assign UB        = ctl_q.ub;
    assign LB        = ctl_q.lb;
    assign OE        = ctl_q.oe;
    assign WE        = ctl_q.we;
    assign rdata     = rdata_q;
    assign hex_out   = hex_q;
    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: three instances (WAIT_CYCLES 2, 0, 15) on one SRAM model;
// directed requests push expected ack cycle / rdata, a negedge monitor pops them.
module tb_mem_io_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] S;

    logic        req_a   [3];
    logic        we_a    [3];
    logic [15:0] addr_a  [3];
    logic [15:0] wdata_a [3];
    logic [15:0] rdata_a [3];
    logic [15:0] hex_a   [3];
    logic        ack_a   [3];
    logic        busy_a  [3];
    logic        ce_a    [3];
    logic        ub_a    [3];
    logic        lb_a    [3];
    logic        oe_a    [3];
    logic        wen_a   [3];
    logic [19:0] sa_a    [3];
    wire  [15:0] dq0, dq1, dq2;

    always #5 Clk = ~Clk;

    mem_io_ctrl #(.WAIT_CYCLES(2)) u_w2 (
        .Clk(Clk), .Reset(Reset), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
        .wdata(wdata_a[0]), .S(S), .rdata(rdata_a[0]), .ack(ack_a[0]), .busy(busy_a[0]),
        .hex_out(hex_a[0]), .SRAM_ADDR(sa_a[0]), .SRAM_DQ(dq0), .CE(ce_a[0]),
        .UB(ub_a[0]), .LB(lb_a[0]), .OE(oe_a[0]), .WE(wen_a[0]));

    mem_io_ctrl #(.WAIT_CYCLES(0)) u_w0 (
        .Clk(Clk), .Reset(Reset), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
        .wdata(wdata_a[1]), .S(S), .rdata(rdata_a[1]), .ack(ack_a[1]), .busy(busy_a[1]),
        .hex_out(hex_a[1]), .SRAM_ADDR(sa_a[1]), .SRAM_DQ(dq1), .CE(ce_a[1]),
        .UB(ub_a[1]), .LB(lb_a[1]), .OE(oe_a[1]), .WE(wen_a[1]));

    mem_io_ctrl #(.WAIT_CYCLES(15)) u_w15 (
        .Clk(Clk), .Reset(Reset), .req(req_a[2]), .we(we_a[2]), .addr(addr_a[2]),
        .wdata(wdata_a[2]), .S(S), .rdata(rdata_a[2]), .ack(ack_a[2]), .busy(busy_a[2]),
        .hex_out(hex_a[2]), .SRAM_ADDR(sa_a[2]), .SRAM_DQ(dq2), .CE(ce_a[2]),
        .UB(ub_a[2]), .LB(lb_a[2]), .OE(oe_a[2]), .WE(wen_a[2]));

    // Asynchronous SRAM model shared by all three controllers (only one is active at a time).
    logic [15:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    always @(posedge Clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (!ce_a[0] && !wen_a[0]) mem[sa_a[0][7:0]] <= dq0;
        if (!ce_a[1] && !wen_a[1]) mem[sa_a[1][7:0]] <= dq1;
        if (!ce_a[2] && !wen_a[2]) mem[sa_a[2][7:0]] <= dq2;
    end

    assign dq0 = (!ce_a[0] && !oe_a[0] && wen_a[0]) ? mem[sa_a[0][7:0]] : 16'hzzzz;
    assign dq1 = (!ce_a[1] && !oe_a[1] && wen_a[1]) ? mem[sa_a[1][7:0]] : 16'hzzzz;
    assign dq2 = (!ce_a[2] && !oe_a[2] && wen_a[2]) ? mem[sa_a[2][7:0]] : 16'hzzzz;

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        bit          chk_rd;
    } exp_t;

    exp_t sbq [3][$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (ack_a[i] === 1'b1) begin
                if (sbq[i].size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_ack: inst %0d acked at cyc %0d, expected none", i, cyc);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("ack_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
                    if (e.chk_rd) chk($sformatf("rdata[%0d]", i), 32'(rdata_a[i]), 32'(e.rd));
                end
            end
        end
    end

    // Called at a negedge (cycle 0); returns at the cycle-1 negedge with req dropped.
    task automatic issue(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input int lat, input logic [15:0] rd, input bit chk_rd, input bit push);
        exp_t e;
        req_a[i]   = 1'b1;
        we_a[i]    = w;
        addr_a[i]  = a;
        wdata_a[i] = d;
        if (push) begin
            e.cyc = cyc + lat;
            e.rd = rd;
            e.chk_rd = chk_rd;
            sbq[i].push_back(e);
        end
        @(posedge Clk);
        @(negedge Clk);
        req_a[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk("drain_pending", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset   = 1'b1;
        S       = 16'h0000;
        pl_en   = 1'b0;
        pl_addr = 8'h00;
        pl_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 16'h0; wdata_a[i] = 16'h0;
        end
        // Reset together with a pending request: the request must be dropped.
        req_a[0]  = 1'b1;
        addr_a[0] = 16'h0040;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", 32'(ack_a[i]), 32'd0);
            chk("rst_busy", 32'(busy_a[i]), 32'd0);
            chk("rst_strobes", 32'({ce_a[i], ub_a[i], lb_a[i], oe_a[i], wen_a[i]}), 32'h1F);
            chk("rst_sram_addr", 32'(sa_a[i]), 32'd0);
            chk("rst_rdata", 32'(rdata_a[i]), 32'd0);
            chk("rst_hex", 32'(hex_a[i]), 32'd0);
        end
        Reset    = 1'b0;
        req_a[0] = 1'b0;
        @(negedge Clk);
        chk("rst_req_discarded", 32'(busy_a[0]), 32'd0);

        pl_en = 1'b1; pl_addr = 8'h40; pl_data = 16'h1234;
        @(negedge Clk);
        pl_en = 1'b0;

        // Read, WAIT_CYCLES=2, with req toggled while busy.
        issue(0, 1'b0, 16'h0040, 16'h0000, 4, 16'h1234, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) req_a[0] = 1'b1;
            if (k == 3) req_a[0] = 1'b0;
            chk("rd_ce", 32'(ce_a[0]), 32'(k > 3));
            chk("rd_oe", 32'(oe_a[0]), 32'(k > 3));
            chk("rd_we_high", 32'(wen_a[0]), 32'd1);
            chk("rd_busy", 32'(busy_a[0]), 32'd1);
            @(negedge Clk);
        end
        drain();

        // Write, WAIT_CYCLES=2.
        issue(0, 1'b1, 16'h0041, 16'hBEEF, 5, 16'h0000, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            chk("wr_we", 32'(wen_a[0]), 32'(k > 3));
            chk("wr_ce", 32'(ce_a[0]), 32'(k > 4));
            chk("wr_oe_high", 32'(oe_a[0]), 32'd1);
            if (k <= 4) chk("wr_dq", 32'(dq0), 32'h0000BEEF);
            @(negedge Clk);
        end
        drain();
        chk("rdata_hold_after_write", 32'(rdata_a[0]), 32'h1234);
        issue(0, 1'b0, 16'h0041, 16'h0000, 4, 16'hBEEF, 1'b1, 1'b1);
        drain();
        issue(0, 1'b0, 16'h0040, 16'h0000, 4, 16'h1234, 1'b1, 1'b1);
        drain();

        // Memory-mapped I/O.
        S = 16'h00A5;
        issue(0, 1'b0, 16'hFFFF, 16'h0000, 2, 16'h00A5, 1'b1, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            chk("io_rd_strobes", 32'({ce_a[0], ub_a[0], lb_a[0], oe_a[0], wen_a[0]}), 32'h1F);
            @(negedge Clk);
        end
        drain();
        issue(0, 1'b1, 16'hFFFF, 16'h0C3F, 2, 16'h0000, 1'b0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            chk("io_wr_strobes", 32'({ce_a[0], ub_a[0], lb_a[0], oe_a[0], wen_a[0]}), 32'h1F);
            @(negedge Clk);
        end
        drain();
        chk("io_hex", 32'(hex_a[0]), 32'h0C3F);
        chk("io_rdata_hold", 32'(rdata_a[0]), 32'h00A5);

        // Reset asserted in cycle 2 of a write: no ack may follow.
        issue(0, 1'b1, 16'h0042, 16'hDEAD, 0, 16'h0000, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rstw_busy", 32'(busy_a[0]), 32'd0);
        chk("rstw_we", 32'(wen_a[0]), 32'd1);
        chk("rstw_ce", 32'(ce_a[0]), 32'd1);
        chk("rstw_hex", 32'(hex_a[0]), 32'd0);
        chk("rstw_rdata", 32'(rdata_a[0]), 32'd0);
        chk("rstw_sram_addr", 32'(sa_a[0]), 32'd0);
        Reset = 1'b0;
        repeat (8) @(negedge Clk);
        chk("rstw_idle", 32'(busy_a[0]), 32'd0);

        // Back-to-back reads, WAIT_CYCLES=0, req held high.
        begin
            exp_t e;
            req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 16'h0040;
            e.rd = 16'h1234; e.chk_rd = 1'b1;
            e.cyc = cyc + 2; sbq[1].push_back(e);
            e.cyc = cyc + 5; sbq[1].push_back(e);
            for (int k = 1; k <= 4; k++) begin
                @(negedge Clk);
                chk("b2b_busy", 32'(busy_a[1]), 32'(k != 3));
            end
            req_a[1] = 1'b0;
        end
        drain();

        // WAIT_CYCLES=0 write and readback.
        issue(1, 1'b1, 16'h0044, 16'h5A5A, 3, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(1, 1'b0, 16'h0044, 16'h0000, 2, 16'h5A5A, 1'b1, 1'b1);
        drain();

        // WAIT_CYCLES=15 read, write and readback.
        issue(2, 1'b0, 16'h0040, 16'h0000, 17, 16'h1234, 1'b1, 1'b1);
        drain();
        issue(2, 1'b1, 16'h0045, 16'h77AA, 18, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(2, 1'b0, 16'h0045, 16'h0000, 17, 16'h77AA, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
